// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard scoreboard and its divider interlock.
package hazard_pkg;

  // Post-ID stage indices; a forward select of k steers from the stage-k register.
  localparam int unsigned ST_EX = 1;
  localparam int unsigned ST_ME = 2;
  localparam int unsigned ST_WB = 3;

  // Stage whose output first carries the result.
  localparam int unsigned AVAIL_ALU = 1;
  localparam int unsigned AVAIL_MEM = 2;

  // Forward select 0 always means "take the register file value".
  localparam int unsigned FWD_RF = 0;

  // Tag field widths (32 architectural registers, 2-bit avail stage).
  localparam int unsigned TAG_RW  = 5;
  localparam int unsigned TAG_AVW = 2;

  typedef struct packed {
    logic               v;
    logic [TAG_RW-1:0]  wreg;
    logic [TAG_AVW-1:0] avail;
  } tag_t;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID decode fields in, stall/flush/forward controls out.
interface hazard_scoreboard_if #(
  parameter int unsigned NREG   = 32,
  parameter int unsigned NSTAGE = 4,
  parameter int unsigned AVW    = 2
);
  localparam int unsigned RW   = $clog2(NREG);
  localparam int unsigned SELW = $clog2(NSTAGE + 1);

  logic            valid_d;
  logic [RW-1:0]   rs_d;
  logic [RW-1:0]   rt_d;
  logic            use_rs_d;
  logic            use_rt_d;
  logic            need_d;
  logic [RW-1:0]   wreg_d;
  logic            regwrite_d;
  logic [AVW-1:0]  avail_d;
  logic            is_div_d;
  logic            hilo_rd_d;
  logic            ext_stall;
  logic            except_flush;

  logic            stall_d;
  logic            flush_e;
  logic [SELW-1:0] fwd_a_d;
  logic [SELW-1:0] fwd_b_d;
  logic [SELW-1:0] fwd_a_e;
  logic [SELW-1:0] fwd_b_e;
  logic            div_busy;

  modport master (
    output valid_d, rs_d, rt_d, use_rs_d, use_rt_d, need_d, wreg_d, regwrite_d,
           avail_d, is_div_d, hilo_rd_d, ext_stall, except_flush,
    input  stall_d, flush_e, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, div_busy
  );

  modport slave (
    input  valid_d, rs_d, rt_d, use_rs_d, use_rt_d, need_d, wreg_d, regwrite_d,
           avail_d, is_div_d, hilo_rd_d, ext_stall, except_flush,
    output stall_d, flush_e, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, div_busy
  );
endinterface

// File: rtl/hazard_div_fsm.sv
// Multi-cycle divider occupancy tracker: busy from issue until HI/LO are valid.
module hazard_div_fsm
  import hazard_pkg::*;
#(
  parameter int unsigned DIV_LAT = 36
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic hold,
  input  logic flush,
  output logic busy
);
  localparam int unsigned CW = $clog2(DIV_LAT);

  div_state_e    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  // State and countdown registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: an exception kills the divide; memory stalls freeze the countdown.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = DIV_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            state_nxt = DIV_BUSY;
            cnt_nxt   = CW'(DIV_LAT - 1);
          end
        end
        DIV_BUSY: begin
          if (!hold) begin
            if (cnt == '0) state_nxt = DIV_IDLE;
            else           cnt_nxt   = cnt - CW'(1);
          end
        end
        default: state_nxt = DIV_IDLE;
      endcase
    end
  end

  assign busy = (state == DIV_BUSY);

endmodule

// File: rtl/hazard_scoreboard.sv
// Depth-parametrised hazard unit: tracks in-flight writes and drives stall, bubble
// and forward selects for the ID and EX operand muxes.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG    = 32,
  parameter int unsigned NSTAGE  = 4,
  parameter int unsigned AVW     = 2,
  parameter int unsigned DIV_LAT = 36
) (
  input  logic               clk,
  input  logic               resetn,
  hazard_scoreboard_if.slave hz
);
  localparam int unsigned RW   = $clog2(NREG);
  localparam int unsigned SELW = $clog2(NSTAGE + 1);

  tag_t [NSTAGE:1]   tags;
  tag_t              id_tag;
  logic [NSTAGE-1:0] match_a, match_b;
  logic [AVW-1:0]    avail_in;
  logic              hit_a, hit_b;
  int unsigned       k_a, k_b, av_a, av_b;
  logic              haz_a, haz_b, div_busy, div_intlk, hold;
  logic              stall_int, flush_int, id_write, div_start;
  logic [SELW-1:0]   sel_a_d, sel_b_d, sel_a_e, sel_b_e;
  logic [SELW-1:0]   fwd_a_e, fwd_b_e;

  // Select for a match at stage k when the operand is needed n stages after ID.
  function automatic logic [SELW-1:0] fwd_sel(input logic hit, input int unsigned k,
                                               input int unsigned n);
    fwd_sel = '0;
    if (hit && (k + n <= NSTAGE)) fwd_sel = SELW'(k + n);
  endfunction

  // Per-stage source compare.
  for (genvar k = 1; k <= NSTAGE; k++) begin : g_match
    assign match_a[k-1] = tags[k].v && (tags[k].wreg == TAG_RW'(hz.rs_d));
    assign match_b[k-1] = tags[k].v && (tags[k].wreg == TAG_RW'(hz.rt_d));
  end

  // Youngest matching stage wins; scanning old-to-young leaves the youngest.
  always_comb begin
    hit_a = 1'b0; k_a = 0; av_a = 0;
    hit_b = 1'b0; k_b = 0; av_b = 0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (match_a[k-1]) begin hit_a = 1'b1; k_a = 32'(k); av_a = 32'(tags[k].avail); end
      if (match_b[k-1]) begin hit_b = 1'b1; k_b = 32'(k); av_b = 32'(tags[k].avail); end
    end
    hit_a = hit_a & hz.use_rs_d & (hz.rs_d != RW'(0));
    hit_b = hit_b & hz.use_rt_d & (hz.rt_d != RW'(0));
  end

  // Hazard when the producing stage has not yet reached its avail stage.
  always_comb begin
    haz_a   = hit_a && (k_a + 32'(hz.need_d) <= av_a);
    haz_b   = hit_b && (k_b + 32'(hz.need_d) <= av_b);
    sel_a_d = fwd_sel(hit_a, k_a, 0);
    sel_b_d = fwd_sel(hit_b, k_b, 0);
    sel_a_e = fwd_sel(hit_a, k_a, 1);
    sel_b_e = fwd_sel(hit_b, k_b, 1);
  end

  assign div_intlk = div_busy & (hz.is_div_d | hz.hilo_rd_d);
  assign hold      = (haz_a | haz_b | div_intlk) & ~hz.except_flush;
  assign stall_int = resetn & ((hz.valid_d & hold) | hz.ext_stall);
  assign flush_int = resetn & hold & ~hz.ext_stall;
  assign id_write  = ~stall_int & hz.valid_d & hz.regwrite_d & (hz.wreg_d != RW'(0));
  assign div_start = ~stall_int & hz.valid_d & hz.is_div_d;
  assign avail_in  = hz.avail_d;

  // Only real writers enter the pipeline; everything else is an invalid bubble.
  always_comb begin
    id_tag = '0;
    if (id_write) begin
      id_tag.v     = 1'b1;
      id_tag.wreg  = TAG_RW'(hz.wreg_d);
      id_tag.avail = TAG_AVW'(avail_in);
    end
  end

  // Tag pipeline: exception clears, memory stall freezes, otherwise shift.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tags <= '0;
    end else if (hz.except_flush) begin
      tags <= '0;
    end else if (!hz.ext_stall) begin
      for (int k = NSTAGE; k >= 2; k--) tags[k] <= tags[k-1];
      tags[ST_EX] <= id_tag;
    end
  end

  // EX forward selects follow the instruction from ID into EX.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fwd_a_e <= '0;
      fwd_b_e <= '0;
    end else if (hz.except_flush) begin
      fwd_a_e <= '0;
      fwd_b_e <= '0;
    end else if (!hz.ext_stall) begin
      if (flush_int) begin
        fwd_a_e <= '0;
        fwd_b_e <= '0;
      end else if (!stall_int) begin
        fwd_a_e <= hz.valid_d ? sel_a_e : '0;
        fwd_b_e <= hz.valid_d ? sel_b_e : '0;
      end
    end
  end

  hazard_div_fsm #(.DIV_LAT(DIV_LAT)) u_div (
    .clk    (clk),
    .resetn (resetn),
    .start  (div_start),
    .hold   (hz.ext_stall),
    .flush  (hz.except_flush),
    .busy   (div_busy)
  );

  assign hz.stall_d  = stall_int;
  assign hz.flush_e  = flush_int;
  assign hz.fwd_a_d  = resetn ? sel_a_d : '0;
  assign hz.fwd_b_d  = resetn ? sel_b_d : '0;
  assign hz.fwd_a_e  = fwd_a_e;
  assign hz.fwd_b_e  = fwd_b_e;
  assign hz.div_busy = div_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scenario bench for hazard_scoreboard.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic clk;
  logic resetn;
  int   total;
  int   bad;

  hazard_scoreboard_if #(.NREG(32), .NSTAGE(4), .AVW(2)) hz ();

  hazard_scoreboard #(.NREG(32), .NSTAGE(4), .AVW(2), .DIV_LAT(36)) dut (
    .clk    (clk),
    .resetn (resetn),
    .hz     (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic set_id(input logic v, input int rs, input int rt, input logic urs,
                        input logic urt, input logic need, input int wreg,
                        input logic rw, input int av, input logic dv, input logic hl);
    hz.valid_d    = v;
    hz.rs_d       = 5'(rs);
    hz.rt_d       = 5'(rt);
    hz.use_rs_d   = urs;
    hz.use_rt_d   = urt;
    hz.need_d     = need;
    hz.wreg_d     = 5'(wreg);
    hz.regwrite_d = rw;
    hz.avail_d    = 2'(av);
    hz.is_div_d   = dv;
    hz.hilo_rd_d  = hl;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    hz.ext_stall    = 1'b0;
    hz.except_flush = 1'b0;
    repeat (6) step();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    nop();
    hz.except_flush = 1'b0;
    hz.ext_stall    = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    total++; if (hz.stall_d !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", hz.stall_d); end
    total++; if (hz.flush_e !== 1'b0) begin bad++; $display("FAIL reset_flush got=%0b exp=0", hz.flush_e); end
    total++; if (hz.fwd_a_e !== 3'd0) begin bad++; $display("FAIL reset_fwd_a_e got=%0d exp=0", hz.fwd_a_e); end
    total++; if (hz.fwd_b_e !== 3'd0) begin bad++; $display("FAIL reset_fwd_b_e got=%0d exp=0", hz.fwd_b_e); end
    total++; if (hz.div_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", hz.div_busy); end
    hz.ext_stall = 1'b0;
    resetn = 1'b1;
    step();
  endtask

  task automatic test_alu_fwd();
    set_id(1, 1, 2, 1, 1, 1, 3, 1, AVAIL_ALU, 0, 0); #1;   // ADD r3,r1,r2
    total++; if (hz.stall_d !== 1'b0) begin bad++; $display("FAIL alu_prod_stall got=%0b exp=0", hz.stall_d); end
    step();
    set_id(1, 3, 3, 1, 1, 1, 4, 1, AVAIL_ALU, 0, 0); #1;   // ADD r4,r3,r3
    total++; if (hz.stall_d !== 1'b0) begin bad++; $display("FAIL alu_dep_stall got=%0b exp=0", hz.stall_d); end
    step();
    nop(); #1;
    total++; if (hz.fwd_a_e !== 3'd2) begin bad++; $display("FAIL alu_fwd_a_e got=%0d exp=2", hz.fwd_a_e); end
    total++; if (hz.fwd_b_e !== 3'd2) begin bad++; $display("FAIL alu_fwd_b_e got=%0d exp=2", hz.fwd_b_e); end
    drain();
    set_id(1, 1, 2, 1, 1, 1, 3, 1, AVAIL_ALU, 0, 0); step();
    set_id(1, 1, 2, 1, 1, 1, 8, 1, AVAIL_ALU, 0, 0); step();  // independent
    set_id(1, 3, 3, 1, 1, 1, 4, 1, AVAIL_ALU, 0, 0); #1;
    total++; if (hz.stall_d !== 1'b0) begin bad++; $display("FAIL gap_dep_stall got=%0b exp=0", hz.stall_d); end
    step();
    nop(); #1;
    total++; if (hz.fwd_a_e !== 3'd3) begin bad++; $display("FAIL gap_fwd_a_e got=%0d exp=3", hz.fwd_a_e); end
    total++; if (hz.fwd_b_e !== 3'd3) begin bad++; $display("FAIL gap_fwd_b_e got=%0d exp=3", hz.fwd_b_e); end
    drain();
  endtask

  task automatic test_load_use();
    set_id(1, 1, 0, 1, 0, 1, 5, 1, AVAIL_MEM, 0, 0); step();  // LW r5
    set_id(1, 5, 0, 1, 0, 1, 6, 1, AVAIL_ALU, 0, 0); #1;      // ADD r6,r5
    total++; if (hz.stall_d !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0b exp=1", hz.stall_d); end
    total++; if (hz.flush_e !== 1'b1) begin bad++; $display("FAIL lu_flush got=%0b exp=1", hz.flush_e); end
    step(); #1;
    total++; if (hz.stall_d !== 1'b0) begin bad++; $display("FAIL lu_release got=%0b exp=0", hz.stall_d); end
    total++; if (hz.fwd_a_e !== 3'd0) begin bad++; $display("FAIL lu_bubble_fwd got=%0d exp=0", hz.fwd_a_e); end
    step();
    nop(); #1;
    total++; if (hz.fwd_a_e !== 3'd3) begin bad++; $display("FAIL lu_fwd_a_e got=%0d exp=3", hz.fwd_a_e); end
    drain();
    set_id(1, 1, 0, 1, 0, 1, 5, 1, AVAIL_MEM, 0, 0); step();  // LW r5
    set_id(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0); #1;              // BEQ r5
    total++; if (hz.stall_d !== 1'b1) begin bad++; $display("FAIL lb_stall1 got=%0b exp=1", hz.stall_d); end
    step(); #1;
    total++; if (hz.stall_d !== 1'b1) begin bad++; $display("FAIL lb_stall2 got=%0b exp=1", hz.stall_d); end
    step(); #1;
    total++; if (hz.stall_d !== 1'b0) begin bad++; $display("FAIL lb_release got=%0b exp=0", hz.stall_d); end
    total++; if (hz.fwd_a_d !== 3'd3) begin bad++; $display("FAIL lb_fwd_a_d got=%0d exp=3", hz.fwd_a_d); end
    step();
    drain();
  endtask

  task automatic test_branch();
    set_id(1, 1, 2, 1, 1, 1, 7, 1, AVAIL_ALU, 0, 0); step();  // ADD r7
    set_id(1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0); #1;              // BEQ r7
    total++; if (hz.stall_d !== 1'b1) begin bad++; $display("FAIL br_stall got=%0b exp=1", hz.stall_d); end
    step(); #1;
    total++; if (hz.stall_d !== 1'b0) begin bad++; $display("FAIL br_release got=%0b exp=0", hz.stall_d); end
    total++; if (hz.fwd_a_d !== 3'd2) begin bad++; $display("FAIL br_fwd_a_d got=%0d exp=2", hz.fwd_a_d); end
    step();
    drain();
    set_id(1, 1, 2, 1, 1, 1, 0, 1, AVAIL_ALU, 0, 0); step();  // ADD r0
    set_id(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0); #1;              // BEQ r0,r0
    total++; if (hz.stall_d !== 1'b0) begin bad++; $display("FAIL r0_stall got=%0b exp=0", hz.stall_d); end
    total++; if (hz.fwd_a_d !== 3'd0) begin bad++; $display("FAIL r0_fwd_a_d got=%0d exp=0", hz.fwd_a_d); end
    step();
    drain();
  endtask

  task automatic test_div();
    int n;
    int viol;
    set_id(1, 1, 2, 1, 1, 1, 0, 0, 0, 1, 0); #1;              // DIV
    total++; if (hz.stall_d !== 1'b0) begin bad++; $display("FAIL div_issue_stall got=%0b exp=0", hz.stall_d); end
    step();
    set_id(1, 0, 0, 0, 0, 1, 9, 1, AVAIL_ALU, 0, 1);          // MFHI r9
    n = 0; viol = 0;
    while (hz.div_busy && n < 200) begin
      #1;
      if (hz.stall_d !== 1'b1) viol++;
      n++;
      step();
    end
    total++; if (n != 36) begin bad++; $display("FAIL div_busy_len got=%0d exp=36", n); end
    total++; if (viol != 0) begin bad++; $display("FAIL div_mfhi_held got=%0d unstalled cycles exp=0", viol); end
    #1;
    total++; if (hz.stall_d !== 1'b0) begin bad++; $display("FAIL div_mfhi_accept got=%0b exp=0", hz.stall_d); end
    step();
    drain();
  endtask

  task automatic test_div_ext();
    int n;
    set_id(1, 1, 2, 1, 1, 1, 0, 0, 0, 1, 0); step();          // DIV
    set_id(1, 1, 2, 1, 1, 1, 0, 0, 0, 1, 0); #1;              // back-to-back DIV
    total++; if (hz.stall_d !== 1'b1) begin bad++; $display("FAIL div2_stall got=%0b exp=1", hz.stall_d); end
    total++; if (hz.flush_e !== 1'b1) begin bad++; $display("FAIL div2_flush got=%0b exp=1", hz.flush_e); end
    n = 1;
    step();
    set_id(1, 0, 0, 0, 0, 1, 9, 1, AVAIL_ALU, 0, 1);
    while (hz.div_busy && n < 200) begin
      hz.ext_stall = (n >= 10 && n < 15);
      #1;
      n++;
      step();
    end
    hz.ext_stall = 1'b0;
    total++; if (n != 41) begin bad++; $display("FAIL div_ext_len got=%0d exp=41", n); end
    drain();
  endtask

  task automatic test_except();
    set_id(1, 1, 2, 1, 1, 1, 0, 0, 0, 1, 0); step();          // DIV
    set_id(1, 1, 0, 1, 0, 1, 5, 1, AVAIL_MEM, 0, 0); step();  // LW r5
    nop(); step();                                            // LW now in ME
    set_id(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0); #1;              // BEQ r5
    total++; if (hz.stall_d !== 1'b1) begin bad++; $display("FAIL exc_pre_stall got=%0b exp=1", hz.stall_d); end
    hz.except_flush = 1'b1; #1;
    total++; if (hz.stall_d !== 1'b0) begin bad++; $display("FAIL exc_stall got=%0b exp=0", hz.stall_d); end
    total++; if (hz.flush_e !== 1'b0) begin bad++; $display("FAIL exc_flush got=%0b exp=0", hz.flush_e); end
    step();
    hz.except_flush = 1'b0;
    set_id(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    total++; if (hz.stall_d !== 1'b0) begin bad++; $display("FAIL exc_after_stall got=%0b exp=0", hz.stall_d); end
    total++; if (hz.div_busy !== 1'b0) begin bad++; $display("FAIL exc_busy got=%0b exp=0", hz.div_busy); end
    total++; if (hz.fwd_a_d !== 3'd0) begin bad++; $display("FAIL exc_fwd_a_d got=%0d exp=0", hz.fwd_a_d); end
    total++; if (hz.fwd_a_e !== 3'd0) begin bad++; $display("FAIL exc_fwd_a_e got=%0d exp=0", hz.fwd_a_e); end
    step();
    drain();
  endtask

  task automatic test_reset_mid();
    set_id(1, 1, 2, 1, 1, 1, 0, 0, 0, 1, 0); step();          // DIV
    set_id(1, 1, 0, 1, 0, 1, 5, 1, AVAIL_MEM, 0, 0); step();  // LW r5
    set_id(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0); #1;              // BEQ r5
    total++; if (hz.stall_d !== 1'b1) begin bad++; $display("FAIL rm_pre_stall got=%0b exp=1", hz.stall_d); end
    total++; if (hz.div_busy !== 1'b1) begin bad++; $display("FAIL rm_pre_busy got=%0b exp=1", hz.div_busy); end
    resetn = 1'b0; #1;
    total++; if (hz.stall_d !== 1'b0) begin bad++; $display("FAIL rm_stall got=%0b exp=0", hz.stall_d); end
    total++; if (hz.div_busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%0b exp=0", hz.div_busy); end
    total++; if (hz.fwd_a_d !== 3'd0) begin bad++; $display("FAIL rm_fwd_a_d got=%0d exp=0", hz.fwd_a_d); end
    nop();
    step();
    resetn = 1'b1;
    step();
    set_id(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0); #1;              // stale r5 must be gone
    total++; if (hz.stall_d !== 1'b0) begin bad++; $display("FAIL rm_clean_stall got=%0b exp=0", hz.stall_d); end
    step();
    set_id(1, 1, 2, 1, 1, 1, 3, 1, AVAIL_ALU, 0, 0); step();
    set_id(1, 3, 3, 1, 1, 1, 4, 1, AVAIL_ALU, 0, 0); #1;
    total++; if (hz.stall_d !== 1'b0) begin bad++; $display("FAIL rm_dep_stall got=%0b exp=0", hz.stall_d); end
    step();
    nop(); #1;
    total++; if (hz.fwd_a_e !== 3'd2) begin bad++; $display("FAIL rm_fwd_a_e got=%0d exp=2", hz.fwd_a_e); end
    drain();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_branch();
    test_div();
    test_div_ext();
    test_except();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
